// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle for aes_round_ctrl.
// The master modport is the controller; the slave modport is the host/datapath side.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic       reg_en;
    logic       reg_clr;
    logic       load_sel;
    logic       last_round;
    logic [7:0] rcon;
    logic [3:0] round;
    logic       busy;

    modport master (
        input  in_valid, abort, out_ready,
        output in_ready, out_valid, reg_en, reg_clr, load_sel,
               last_round, rcon, round, busy
    );

    modport slave (
        output in_valid, abort, out_ready,
        input  in_ready, out_valid, reg_en, reg_clr, load_sel,
               last_round, rcon, round, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer driving a single-round datapath through a feedback register.
// Optional AES_CTRL_PERF_EN adds blocks_done / stall_cycles performance counters.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.master bus
`ifdef AES_CTRL_PERF_EN
    ,
    output logic [31:0]      blocks_done,
    output logic [31:0]      stall_cycles
`endif
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
        $error("aes_round_ctrl: NUM_ROUNDS must be in 1..10");
    end

    localparam logic [3:0] LP_LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic       w_accept_ok;
    logic       w_fire_in;
    logic       w_last;

    function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
        end
    end

    // Abort is applied last so it overrides any accept or round step decided above it.
    always_comb begin
        w_state_nxt    = r_state;
        w_round_nxt    = r_round;
        w_last         = (r_round == LP_LAST_ROUND);
        w_accept_ok    = !bus.abort &&
                         ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready));
        w_fire_in      = w_accept_ok && bus.in_valid;
        bus.in_ready   = w_accept_ok;
        bus.out_valid  = (r_state == ST_DONE);
        bus.reg_en     = w_fire_in;
        bus.reg_clr    = bus.abort;
        bus.load_sel   = w_fire_in;
        bus.last_round = 1'b0;
        bus.rcon       = 8'h00;
        bus.round      = r_round;
        bus.busy       = w_fire_in;

        case (r_state)
            ST_IDLE: begin
                if (w_fire_in) begin
                    w_state_nxt = ST_ROUND;
                    w_round_nxt = 4'd1;
                end
            end
            ST_ROUND: begin
                bus.reg_en     = 1'b1;
                bus.last_round = w_last;
                bus.rcon       = f_rcon(r_round);
                bus.busy       = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            ST_DONE: begin
                if (w_fire_in) begin
                    w_state_nxt = ST_ROUND;
                    w_round_nxt = 4'd1;
                end else if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_round_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_round_nxt = 4'd0;
            end
        endcase

        if (bus.abort) begin
            bus.reg_en  = 1'b0;
            w_state_nxt = ST_IDLE;
            w_round_nxt = 4'd0;
        end
    end

`ifdef AES_CTRL_PERF_EN
    logic [31:0] r_blocks_done;
    logic [31:0] r_stall_cycles;
    logic        w_out_valid;

    assign w_out_valid = (r_state == ST_DONE);

    // Counters observe the output handshake only, so abort leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blocks_done  <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (w_out_valid && bus.out_ready) begin
                r_blocks_done <= r_blocks_done + 32'd1;
            end
            if (w_out_valid && !bus.out_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign blocks_done  = r_blocks_done;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule
